// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an idle-high asynchronous input; resets to 1.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional parity, 1/2 stop bits,
// valid/ready output holding one frame, overrun pulse when a frame is dropped.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = 4;
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    logic                 rxs;
    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 parity_err_int;
    logic                 frame_err_int;
    logic                 break_int;
    logic                 tick;
    logic                 fe_now;
    logic                 brk_now;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (rxs)
    );

    // Flag values including the stop sample taken this cycle; only the first
    // stop bit contributes to break detection.
    always_comb begin
        tick    = (cnt == CNT_FULL);
        fe_now  = frame_err_int | ~rxs;
        brk_now = (idx == '0) ? (break_int & ~rxs) : break_int;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            par_acc        <= 1'b0;
            parity_err_int <= 1'b0;
            frame_err_int  <= 1'b0;
            break_int      <= 1'b0;
            dout           <= '0;
            valid          <= 1'b0;
            parity_err     <= 1'b0;
            frame_err      <= 1'b0;
            break_det      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (valid && ready)
                valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rxs)
                        state <= ST_START;
                end

                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= ST_IDLE;
                        end else begin
                            state          <= ST_DATA;
                            idx            <= '0;
                            par_acc        <= 1'b0;
                            parity_err_int <= 1'b0;
                            frame_err_int  <= 1'b0;
                            break_int      <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        cnt       <= '0;
                        shreg     <= {rxs, shreg[DATA_BITS-1:1]};
                        par_acc   <= par_acc ^ rxs;
                        break_int <= break_int & ~rxs;
                        if (idx == LAST_DATA) begin
                            idx   <= '0;
                            state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        cnt            <= '0;
                        parity_err_int <= (PARITY == PARITY_ODD) ? ~(par_acc ^ rxs)
                                                                 :  (par_acc ^ rxs);
                        break_int      <= break_int & ~rxs;
                        state          <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        cnt           <= '0;
                        frame_err_int <= fe_now;
                        break_int     <= brk_now;
                        if (idx == LAST_STOP) begin
                            idx <= '0;
                            if (!valid || ready) begin
                                dout       <= shreg;
                                valid      <= 1'b1;
                                parity_err <= parity_err_int;
                                frame_err  <= fe_now;
                                break_det  <= brk_now;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= fe_now ? ST_WAIT_IDLE : ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WAIT_IDLE: begin
                    if (!rxs) begin
                        cnt <= '0;
                    end else if (tick) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
